fnd_scan_controller: RTL and testbench
======================================

# fnd_scan_controller

Time-multiplexed scan controller for the 4-digit seven-segment (FND) display. It snapshots a 16-bit BCD value once per frame and steps through the four digit positions at a programmable rate. For each slot it drives the digit-select decoder's position and blank-enable inputs, plus the BCD nibble and decimal point for the segment encoder. A blanking interval at the start of every slot suppresses ghosting, and optional leading-zero suppression is applied.

## Interface
- CLK_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range ≥ 2
- BLANK_CYCLES, 1000, cycles at the start of each slot during which all digits are off; legal range 1 ≤ BLANK_CYCLES < CLK_DIV
- i_clk  input  1  system clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_value  input  16  four BCD digits; [3:0] is digit 0 (least significant, rightmost)
- i_dp_mask  input  4  decimal point per digit; bit k belongs to digit k
- i_lz_blank  input  1  1 = suppress leading zeros
- i_display_on  input  1  0 = all digits dark
- o_digit_position  output  2  current digit index; feeds the decoder position input
- o_digit_blank  output  1  1 = all digits off; feeds the decoder enable (i_En) input
- o_bcd  output  4  BCD nibble for the current digit
- o_dp  output  1  decimal point for the current digit, active-high
- o_frame_start  output  1  one-cycle pulse when a new frame snapshot has been taken

## Operation
- State is held in four registers:
  - slot counter `cnt`, range 0..CLK_DIV-1
  - digit pointer `pos`, 2 bits
  - snapshot registers `snap_value`, `snap_dp`, `snap_lz`
- Counter rule, applied every clock:
  - if cnt == CLK_DIV-1: cnt ← 0 and pos ← pos+1, wrapping 3→0
  - otherwise: cnt ← cnt+1
- Snapshot: on the edge where pos goes 3→0, capture i_value, i_dp_mask and i_lz_blank into the snapshot registers. The same edge sets the internal frame flag for one cycle. Inputs are not sampled at any other time, so the display never shows a torn value.
- Phases within a slot:
  - BLANK phase: cnt < BLANK_CYCLES
  - SHOW phase: cnt ≥ BLANK_CYCLES
- Leading-zero rule: digit k (k = 1..3) is suppressed when snap_lz = 1 and snapshot digits k..3 are all 0. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- Blank condition for a slot = BLANK phase, OR i_display_on = 0, OR the leading-zero rule suppresses this digit.
- Output register stage: on every edge, the outputs capture a function of the current state:
  - o_digit_position ← pos
  - o_digit_blank ← blank condition
  - o_bcd ← snap_value[4·pos +: 4]
  - o_dp ← snap_dp[pos] AND NOT blank condition
  - o_frame_start ← frame flag
- i_display_on is not snapshotted. It takes effect through the output stage one cycle after it changes. The counter and pointer keep running while the display is off.
- Snapshot digits above 9 are passed through on o_bcd unchanged. Range checking belongs to the segment encoder.

## Timing
- Reset (asynchronous assert, synchronous release) sets:
  - cnt = 0, pos = 0, snapshot = 0, frame flag = 0
  - o_digit_position = 0, o_digit_blank = 1, o_bcd = 0, o_dp = 0, o_frame_start = 0
- The first frame after reset displays the zero snapshot. The first real capture happens on the first 3→0 wrap, 4·CLK_DIV cycles after release.
- Slot period is CLK_DIV cycles; frame period is 4·CLK_DIV cycles.
- All outputs lag internal state by exactly 1 cycle.
- o_digit_blank is 1 for BLANK_CYCLES consecutive cycles at the start of every slot.
- o_digit_position changes only on a cycle where o_digit_blank is 1. Because BLANK_CYCLES ≥ 1, this guarantees no position change ever happens while a digit is lit.
- o_frame_start goes high 1 cycle after the snapshot edge. It is aligned with the first output cycle of digit 0 in the new frame.
- Input changes between snapshots never reach the outputs. i_display_on is the one exception.
- If reset asserts mid-slot, all outputs return to their reset values immediately. The scan restarts at pos 0 with the snapshot cleared.

## Test plan
(All scenarios use CLK_DIV=8, BLANK_CYCLES=2.)
- Reset scan: release reset, i_display_on=1, i_lz_blank=0, i_value=16'h1234, i_dp_mask=0 → frame 1 shows 0000. From cycle 33 onward, o_digit_position steps 0,1,2,3 every 8 cycles with o_bcd 4,3,2,1. o_digit_blank is high for 2 of every 8 cycles. o_frame_start pulses every 32 cycles.
- Tearing guard: change i_value from 16'h1234 to 16'h5678 mid-frame while pos=2 → the remaining digits of that frame still show 2,1. The next frame shows 8,7,6,5.
- Leading-zero suppression: i_value=16'h0040, i_lz_blank=1 → digits 3 and 2 are blank for the whole slot. Digit 1 shows 4 and digit 0 shows 0. With i_value=16'h0000, only digit 0 is lit (shows 0).
- Decimal point: i_dp_mask=4'b0100 → o_dp=1 only during SHOW cycles of digit 2 and 0 during its BLANK cycles. Also check that o_dp is 0 when i_display_on=0.
- Display off: drop i_display_on mid-SHOW → o_digit_blank=1 on the next cycle and o_digit_position keeps advancing. Raise it again → lighting resumes at the next SHOW cycle.
- Reset mid-operation: assert i_reset at pos=2, cnt=5 → outputs go to reset values without waiting for a clock edge. After release, pos=0 and o_bcd=0 until the first capture.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Four-digit seven-segment scan controller: per-frame BCD snapshot, per-slot blanking,
// leading-zero suppression and a registered output stage for the digit decoder/encoder.
module fnd_scan_controller #(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp_mask,
  input  logic        i_lz_blank,
  input  logic        i_display_on,
  output logic [1:0]  o_digit_position,
  output logic        o_digit_blank,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_frame_start
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CntShow = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    pos_q, pos_d;
  logic [15:0]   snap_value_q;
  logic [3:0]    snap_dp_q;
  logic          snap_lz_q;
  logic          frame_q;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    digit_zero;
  logic          lz_sup;
  logic          blank;
  logic [3:0]    bcd;

  always_comb begin
    slot_end = (cnt_q == CntLast);
    wrap     = slot_end && (pos_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
    pos_d    = slot_end ? pos_q + 2'd1 : pos_q;

    for (int k = 0; k < 4; k++) begin
      digit_zero[k] = (snap_value_q[4*k +: 4] == 4'd0);
    end

    // A digit is dropped only when it and every more significant digit are zero.
    lz_sup = 1'b0;
    unique case (pos_q)
      2'd0: lz_sup = 1'b0;
      2'd1: lz_sup = snap_lz_q & digit_zero[3] & digit_zero[2] & digit_zero[1];
      2'd2: lz_sup = snap_lz_q & digit_zero[3] & digit_zero[2];
      2'd3: lz_sup = snap_lz_q & digit_zero[3];
      default: lz_sup = 1'b0;
    endcase

    blank = (cnt_q < CntShow) | ~i_display_on | lz_sup;
    bcd   = snap_value_q[{pos_q, 2'b00} +: 4];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q        <= '0;
      pos_q        <= 2'd0;
      snap_value_q <= 16'd0;
      snap_dp_q    <= 4'd0;
      snap_lz_q    <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      frame_q <= wrap;
      if (wrap) begin
        snap_value_q <= i_value;
        snap_dp_q    <= i_dp_mask;
        snap_lz_q    <= i_lz_blank;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_digit_position <= 2'd0;
      o_digit_blank    <= 1'b1;
      o_bcd            <= 4'd0;
      o_dp             <= 1'b0;
      o_frame_start    <= 1'b0;
    end else begin
      o_digit_position <= pos_q;
      o_digit_blank    <= blank;
      o_bcd            <= bcd;
      o_dp             <= snap_dp_q[pos_q] & ~blank;
      o_frame_start    <= frame_q;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with CLK_DIV=8, BLANK_CYCLES=2.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp_mask = 4'b0000;
  logic        lz_blank = 1'b0;
  logic        display_on = 1'b1;
  logic [1:0]  digit_position;
  logic        digit_blank;
  logic [3:0]  bcd;
  logic        dp;
  logic        frame_start;

  int total = 0;
  int bad = 0;
  int k = 0;
  int nblank;

  fnd_scan_controller #(
    .CLK_DIV     (8),
    .BLANK_CYCLES(2)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_value         (value),
    .i_dp_mask       (dp_mask),
    .i_lz_blank      (lz_blank),
    .i_display_on    (display_on),
    .o_digit_position(digit_position),
    .o_digit_blank   (digit_blank),
    .o_bcd           (bcd),
    .o_dp            (dp),
    .o_frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] p, input logic b,
                         input logic [3:0] v, input logic d);
    chk({tag, ".pos"}, 16'(digit_position), 16'(p));
    chk({tag, ".blank"}, 16'(digit_blank), 16'(b));
    chk({tag, ".bcd"}, 16'(bcd), 16'(v));
    chk({tag, ".dp"}, 16'(dp), 16'(d));
  endtask

  // Output after edge k reflects internal state after edge k-1.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk_all("rst_async", 2'd0, 1'b1, 4'd0, 1'b0);
    chk("rst_async.frame", 16'(frame_start), 16'd0);
    step();
    step();
    chk_all("rst_held", 2'd0, 1'b1, 4'd0, 1'b0);
    rst = 1'b0;
    k = 0;

    // Frame 1 shows the zero snapshot.
    run_to(1);  chk_all("f1_k1", 2'd0, 1'b1, 4'd0, 1'b0);
    run_to(3);  chk_all("f1_k3", 2'd0, 1'b0, 4'd0, 1'b0);
    run_to(11); chk_all("f1_k11", 2'd1, 1'b0, 4'd0, 1'b0);
    run_to(16);
    nblank = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      nblank += int'(digit_blank);
    end
    chk("blank_per_slot", 16'(nblank), 16'd2);
    run_to(32); chk("f1_k32.frame", 16'(frame_start), 16'd0);

    // Frame 2 shows 1234.
    run_to(33); chk_all("f2_k33", 2'd0, 1'b1, 4'd4, 1'b0);
    chk("f2_k33.frame", 16'(frame_start), 16'd1);
    run_to(34); chk("f2_k34.frame", 16'(frame_start), 16'd0);
    run_to(35); chk_all("f2_k35", 2'd0, 1'b0, 4'd4, 1'b0);
    run_to(40); chk_all("f2_k40", 2'd0, 1'b0, 4'd4, 1'b0);
    run_to(41); chk_all("f2_k41", 2'd1, 1'b1, 4'd3, 1'b0);
    run_to(43); chk_all("f2_k43", 2'd1, 1'b0, 4'd3, 1'b0);

    // Tearing guard: change value while pos=2.
    run_to(52); value = 16'h5678;
    run_to(53); chk_all("tear_k53", 2'd2, 1'b0, 4'd2, 1'b0);
    run_to(59); chk_all("tear_k59", 2'd3, 1'b0, 4'd1, 1'b0);
    run_to(65); chk_all("f3_k65", 2'd0, 1'b1, 4'd8, 1'b0);
    chk("f3_k65.frame", 16'(frame_start), 16'd1);
    run_to(67); chk_all("f3_k67", 2'd0, 1'b0, 4'd8, 1'b0);
    run_to(75); chk_all("f3_k75", 2'd1, 1'b0, 4'd7, 1'b0);
    run_to(83); chk_all("f3_k83", 2'd2, 1'b0, 4'd6, 1'b0);
    run_to(91); chk_all("f3_k91", 2'd3, 1'b0, 4'd5, 1'b0);

    // Leading-zero suppression on 0040.
    value = 16'h0040;
    lz_blank = 1'b1;
    run_to(97);  chk("f4_k97.frame", 16'(frame_start), 16'd1);
    run_to(99);  chk_all("lz_d0", 2'd0, 1'b0, 4'd0, 1'b0);
    run_to(107); chk_all("lz_d1", 2'd1, 1'b0, 4'd4, 1'b0);
    run_to(115); chk_all("lz_d2_show", 2'd2, 1'b1, 4'd0, 1'b0);
    run_to(118); chk_all("lz_d2_late", 2'd2, 1'b1, 4'd0, 1'b0);
    run_to(123); chk_all("lz_d3", 2'd3, 1'b1, 4'd0, 1'b0);

    // All-zero value: only digit 0 lit.
    value = 16'h0000;
    run_to(131); chk_all("lz0_d0", 2'd0, 1'b0, 4'd0, 1'b0);
    run_to(139); chk_all("lz0_d1", 2'd1, 1'b1, 4'd0, 1'b0);
    run_to(147); chk_all("lz0_d2", 2'd2, 1'b1, 4'd0, 1'b0);
    run_to(155); chk_all("lz0_d3", 2'd3, 1'b1, 4'd0, 1'b0);

    // Decimal point on digit 2.
    value = 16'h1234;
    lz_blank = 1'b0;
    dp_mask = 4'b0100;
    run_to(171); chk_all("dp_d1", 2'd1, 1'b0, 4'd3, 1'b0);
    run_to(177); chk_all("dp_d2_blank0", 2'd2, 1'b1, 4'd2, 1'b0);
    run_to(178); chk_all("dp_d2_blank1", 2'd2, 1'b1, 4'd2, 1'b0);
    run_to(179); chk_all("dp_d2_show", 2'd2, 1'b0, 4'd2, 1'b1);

    // Display off mid-SHOW, then back on.
    run_to(180); display_on = 1'b0;
    run_to(181); chk_all("off_k181", 2'd2, 1'b1, 4'd2, 1'b0);
    run_to(182); chk_all("off_k182", 2'd2, 1'b1, 4'd2, 1'b0);
    run_to(185); chk_all("off_k185", 2'd3, 1'b1, 4'd1, 1'b0);
    display_on = 1'b1;
    run_to(186); chk_all("on_k186", 2'd3, 1'b1, 4'd1, 1'b0);
    run_to(187); chk_all("on_k187", 2'd3, 1'b0, 4'd1, 1'b0);

    // Reset mid-operation at pos=2, cnt=5.
    run_to(213); chk_all("pre_rst", 2'd2, 1'b0, 4'd2, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all("mid_rst", 2'd0, 1'b1, 4'd0, 1'b0);
    chk("mid_rst.frame", 16'(frame_start), 16'd0);
    step();
    step();
    rst = 1'b0;
    k = 0;
    run_to(3);  chk_all("rr_k3", 2'd0, 1'b0, 4'd0, 1'b0);
    run_to(11); chk_all("rr_k11", 2'd1, 1'b0, 4'd0, 1'b0);
    run_to(33); chk_all("rr_k33", 2'd0, 1'b1, 4'd4, 1'b0);
    chk("rr_k33.frame", 16'(frame_start), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
